// File: rtl/nec_pkg.sv
// Shared NEC IR protocol definitions: transmitter state encoding and 50 MHz timing constants.
package nec_pkg;

  typedef logic [2:0] nec_tx_state_t;

  localparam nec_tx_state_t S_IDLE       = 3'd0;
  localparam nec_tx_state_t S_LEAD_MARK  = 3'd1;
  localparam nec_tx_state_t S_LEAD_SPACE = 3'd2;
  localparam nec_tx_state_t S_BIT_MARK   = 3'd3;
  localparam nec_tx_state_t S_BIT_SPACE  = 3'd4;
  localparam nec_tx_state_t S_RPT_SPACE  = 3'd5;
  localparam nec_tx_state_t S_STOP_MARK  = 3'd6;
  localparam nec_tx_state_t S_GAP        = 3'd7;

  // Cycle counts at CLOCK_50 = 50 MHz; the decoder derives its bit thresholds from the same values.
  localparam int NEC_T_UNIT   = 28125;
  localparam int NEC_T_LEAD   = 450000;
  localparam int NEC_T_LSPACE = 225000;
  localparam int NEC_T_RSPACE = 112500;
  localparam int NEC_T_ONE    = 84375;
  localparam int NEC_T_GAP    = 500000;
  localparam int NEC_CAR_HALF = 658;
  localparam int NEC_CNT_W    = 20;

  function automatic logic is_mark(input nec_tx_state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// 38 kHz carrier phase generator; held at phase=1 with a cleared counter while en is low,
// so every enabled burst starts on a full high half-period.
module nec_carrier_gen #(
  parameter int CAR_HALF = 658
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic en,
  output logic phase
);

  localparam int PW = $clog2(CAR_HALF + 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == PW'(CAR_HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: frame/repeat-code sequencer driving a carrier-modulated LED line
// plus the bare active-low envelope for loopback into the decoder.
module nec_ir_transmitter
  import nec_pkg::*;
#(
  parameter int T_UNIT   = NEC_T_UNIT,
  parameter int T_LEAD   = NEC_T_LEAD,
  parameter int T_LSPACE = NEC_T_LSPACE,
  parameter int T_RSPACE = NEC_T_RSPACE,
  parameter int T_ONE    = NEC_T_ONE,
  parameter int T_GAP    = NEC_T_GAP,
  parameter int CAR_HALF = NEC_CAR_HALF,
  parameter int CNT_W    = NEC_CNT_W
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       REPEAT,
  input  logic [7:0] ADDR,
  input  logic [7:0] CMD,
  output logic       BUSY,
  output logic       DONE,
  output logic       IRDA_TXD,
  output logic       TX_ENV
);

  localparam logic [CNT_W-1:0] L_UNIT   = CNT_W'(T_UNIT - 1);
  localparam logic [CNT_W-1:0] L_LEAD   = CNT_W'(T_LEAD - 1);
  localparam logic [CNT_W-1:0] L_LSPACE = CNT_W'(T_LSPACE - 1);
  localparam logic [CNT_W-1:0] L_RSPACE = CNT_W'(T_RSPACE - 1);
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(T_ONE - 1);
  localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(T_GAP - 1);

  nec_tx_state_t    state;
  logic [CNT_W-1:0] timer;
  logic [31:0]      shift;
  logic [4:0]       bitcnt;
  logic             rpt;
  logic             done;
  logic             mark;
  logic             phase;

  // Timer is reloaded on every transition, so a state's dwell is exactly its T_x.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      timer  <= '0;
      shift  <= '0;
      bitcnt <= '0;
      rpt    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (timer != '0) begin
        timer <= timer - CNT_W'(1);
      end else begin
        case (state)
          S_IDLE: begin
            // The DONE cycle blocks acceptance so back-to-back requests always see an idle gap.
            if (START && !done) begin
              state  <= S_LEAD_MARK;
              timer  <= L_LEAD;
              shift  <= {~CMD, CMD, ~ADDR, ADDR};
              rpt    <= REPEAT;
              bitcnt <= '0;
            end
          end
          S_LEAD_MARK: begin
            state <= rpt ? S_RPT_SPACE : S_LEAD_SPACE;
            timer <= rpt ? L_RSPACE : L_LSPACE;
          end
          S_LEAD_SPACE: begin
            state <= S_BIT_MARK;
            timer <= L_UNIT;
          end
          S_BIT_MARK: begin
            state <= S_BIT_SPACE;
            timer <= shift[0] ? L_ONE : L_UNIT;
          end
          S_BIT_SPACE: begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 5'd1;
            state  <= (bitcnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            timer  <= L_UNIT;
          end
          S_RPT_SPACE: begin
            state <= S_STOP_MARK;
            timer <= L_UNIT;
          end
          S_STOP_MARK: begin
            state <= S_GAP;
            timer <= L_GAP;
          end
          S_GAP: begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign mark = is_mark(state);

  nec_carrier_gen #(
    .CAR_HALF (CAR_HALF)
  ) u_carrier (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .en       (mark),
    .phase    (phase)
  );

  assign BUSY     = (state != S_IDLE);
  assign DONE     = done;
  assign TX_ENV   = ~mark;
  assign IRDA_TXD = mark & phase;

endmodule
